// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with lock and a starvation limit.
// The memory has a registered read, so read data is steered back one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_en,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    owner_e     owner_q, owner_d;
    logic       lock_hold_q, lock_hold_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_port_q, rd_port_d;

    logic       gnt0, gnt1;
    logic       owner_may_keep;

    function automatic logic [3:0] hold_inc(input logic [3:0] cnt);
        return (cnt >= HOLD_LIMIT) ? HOLD_LIMIT : cnt + 4'd1;
    endfunction

    // The current owner keeps the port under contention only while locked and under the limit.
    assign owner_may_keep = lock_hold_q && (hold_cnt_q < HOLD_LIMIT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                unique case (owner_q)
                    OWN_0: begin
                        gnt0 = owner_may_keep;
                        gnt1 = !owner_may_keep;
                    end
                    OWN_1: begin
                        gnt1 = owner_may_keep;
                        gnt0 = !owner_may_keep;
                    end
                    default: gnt0 = 1'b1;
                endcase
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        owner_d     = owner_q;
        lock_hold_d = 1'b0;
        hold_cnt_d  = 4'd0;
        rd_pend_d   = 1'b0;
        rd_port_d   = rd_port_q;
        if (gnt0) begin
            owner_d     = OWN_0;
            lock_hold_d = m0_lock;
            if (m1_req) begin
                hold_cnt_d = (owner_q == OWN_0) ? hold_inc(hold_cnt_q) : 4'd1;
            end
            rd_pend_d = (m0_we == 4'b0000);
            if (m0_we == 4'b0000) begin
                rd_port_d = 1'b0;
            end
        end else if (gnt1) begin
            owner_d     = OWN_1;
            lock_hold_d = m1_lock;
            if (m0_req) begin
                hold_cnt_d = (owner_q == OWN_1) ? hold_inc(hold_cnt_q) : 4'd1;
            end
            rd_pend_d = (m1_we == 4'b0000);
            if (m1_we == 4'b0000) begin
                rd_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            lock_hold_q <= 1'b0;
            hold_cnt_q  <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_port_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            lock_hold_q <= lock_hold_d;
            hold_cnt_q  <= hold_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_port_q   <= rd_port_d;
        end
    end

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 4'd0;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Read data is shared; rvalid selects the port the pending read belongs to.
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = !reset && rd_pend_q && !rd_port_q;
    assign m1_rvalid = !reset && rd_pend_q && rd_port_q;
    assign m0_rdata  = reset ? 32'd0 : mem_rdata;
    assign m1_rdata  = reset ? 32'd0 : mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, then random traffic against a
// behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_en;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata)
    );

    // Environment memory with registered read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr[9:2]];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model state.
    logic [31:0] refmem [0:255];
    int          m_own;
    bit          m_lk;
    int          m_streak;
    bit          m_pend;
    int          m_pport;
    logic [31:0] m_pdata;

    task automatic model_step();
        bit          rq [2];
        bit          lk [2];
        logic [3:0]  we [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        int          w;
        bit          ev0, ev1;
        rq[0] = m0_req; rq[1] = m1_req; lk[0] = m0_lock; lk[1] = m1_lock;
        we[0] = m0_we;  we[1] = m1_we;  ad[0] = m0_addr; ad[1] = m1_addr;
        wd[0] = m0_wdata; wd[1] = m1_wdata;
        w = -1;
        if (!reset) begin
            if (rq[0] && rq[1]) begin
                if (m_own < 0) w = 0;
                else if (m_lk && m_streak < MAX_HOLD) w = m_own;
                else w = 1 - m_own;
            end else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
        end
        chk("model.m0_gnt", 32'(m0_gnt), 32'(w == 0));
        chk("model.m1_gnt", 32'(m1_gnt), 32'(w == 1));
        chk("model.mem_en", 32'(mem_en), 32'(w >= 0));
        chk("model.mem_we", 32'(mem_we), (w >= 0) ? 32'(we[w]) : 32'd0);
        chk("model.mem_addr", mem_addr, (w >= 0) ? ad[w] : 32'd0);
        chk("model.mem_wdata", mem_wdata, (w >= 0) ? wd[w] : 32'd0);
        ev0 = !reset && m_pend && m_pport == 0;
        ev1 = !reset && m_pend && m_pport == 1;
        chk("model.m0_rvalid", 32'(m0_rvalid), 32'(ev0));
        chk("model.m1_rvalid", 32'(m1_rvalid), 32'(ev1));
        if (ev0) chk("model.m0_rdata", m0_rdata, m_pdata);
        if (ev1) chk("model.m1_rdata", m1_rdata, m_pdata);
        if (reset) begin
            chk("model.m0_rdata_rst", m0_rdata, 32'd0);
            chk("model.m1_rdata_rst", m1_rdata, 32'd0);
        end

        if (reset) begin
            m_own = -1; m_lk = 0; m_streak = 0; m_pend = 0;
        end else if (w >= 0) begin
            if (rq[1-w]) m_streak = (m_own == w) ? ((m_streak + 1 > MAX_HOLD) ? MAX_HOLD : m_streak + 1) : 1;
            else m_streak = 0;
            m_own = w;
            m_lk  = lk[w];
            m_pend = (we[w] == 4'b0000);
            if (m_pend) begin
                m_pport = w;
                m_pdata = refmem[ad[w][9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we[w][b]) refmem[ad[w][9:2]][8*b +: 8] = wd[w][8*b +: 8];
            end
        end else begin
            m_lk = 0; m_streak = 0; m_pend = 0;
        end
    endtask

    typedef struct {
        logic        rst;
        logic        r0; logic l0; logic [3:0] we0; logic [31:0] a0; logic [31:0] d0;
        logic        r1; logic l1; logic [3:0] we1; logic [31:0] a1; logic [31:0] d1;
        logic        eg0; logic eg1; logic ev0; logic ev1; logic [31:0] erd;
        logic [3:0]  ewe; logic [31:0] ea; logic [31:0] ewd;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic drive_idle();
        m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h0101_0101 * i ^ 32'hA5A5_0000;
            refmem[i] = 32'h0101_0101 * i ^ 32'hA5A5_0000;
        end
        mem[8'h40]    = 32'hDEAD_BEEF;
        refmem[8'h40] = 32'hDEAD_BEEF;
        m_own = -1; m_lk = 0; m_streak = 0; m_pend = 0; m_pport = 0; m_pdata = 0;

        //           rst r0 l0 we0    a0        d0            r1 l1 we1    a1        d1            g0 g1 v0 v1 rdata          we     addr      wdata
        tbl[0]  = '{1, 1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,         4'h0, 32'h0,   32'h0};
        tbl[1]  = '{0, 1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h0,         4'h0, 32'h100, 32'h0};
        tbl[2]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 1, 0, 32'hDEADBEEF,  4'h0, 32'h0,   32'h0};
        tbl[3]  = '{1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,         4'h0, 32'h0,   32'h0};
        tbl[4]  = '{0, 1, 0, 4'hF, 32'h10,  32'h11111111, 1, 0, 4'hF, 32'h20, 32'h22222222, 1, 0, 0, 0, 32'h0,         4'hF, 32'h10,  32'h11111111};
        tbl[5]  = '{0, 1, 0, 4'hF, 32'h10,  32'h11111111, 1, 0, 4'hF, 32'h20, 32'h22222222, 0, 1, 0, 0, 32'h0,         4'hF, 32'h20,  32'h22222222};
        tbl[6]  = tbl[4];
        tbl[7]  = tbl[5];
        tbl[8]  = tbl[3]; tbl[8].rst = 0;
        tbl[9]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 4'hF, 32'h30, 32'h33333333, 0, 1, 0, 0, 32'h0,         4'hF, 32'h30,  32'h33333333};
        tbl[10] = '{0, 1, 0, 4'hF, 32'h40,  32'h44444444, 1, 1, 4'hF, 32'h30, 32'h33333333, 0, 1, 0, 0, 32'h0,         4'hF, 32'h30,  32'h33333333};
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];
        tbl[13] = tbl[10];
        tbl[14] = '{0, 1, 0, 4'hF, 32'h40,  32'h44444444, 1, 1, 4'hF, 32'h30, 32'h33333333, 1, 0, 0, 0, 32'h0,         4'hF, 32'h40,  32'h44444444};
        tbl[15] = tbl[10];
        tbl[16] = tbl[8];
        tbl[17] = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 4'h4, 32'h202, 32'h55555555, 0, 1, 0, 0, 32'h0,        4'h4, 32'h202, 32'h55555555};
        tbl[18] = tbl[8];
        tbl[19] = tbl[1];
        tbl[20] = tbl[0];
        tbl[21] = '{0, 1, 1, 4'h0, 32'h100, 32'h0,        1, 0, 4'h0, 32'h20, 32'h0,        1, 0, 0, 0, 32'h0,         4'h0, 32'h100, 32'h0};
        tbl[22] = tbl[2];
        tbl[23] = tbl[8];
        tbl[24] = tbl[8];
        tbl[25] = tbl[8];
        tbl[26] = tbl[5];

        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_step(); @(posedge clk); #1;
        end

        for (int i = 0; i < NV; i++) begin
            reset   = tbl[i].rst;
            m0_req  = tbl[i].r0; m0_lock = tbl[i].l0; m0_we = tbl[i].we0;
            m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
            m1_req  = tbl[i].r1; m1_lock = tbl[i].l1; m1_we = tbl[i].we1;
            m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d.m0_gnt", i), 32'(m0_gnt), 32'(tbl[i].eg0));
            chk($sformatf("vec%0d.m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].eg1));
            chk($sformatf("vec%0d.mem_en", i), 32'(mem_en), 32'(tbl[i].eg0 | tbl[i].eg1));
            chk($sformatf("vec%0d.m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].ev0));
            chk($sformatf("vec%0d.m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].ev1));
            chk($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, tbl[i].ea);
            chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, tbl[i].ewd);
            if (tbl[i].ev0) chk($sformatf("vec%0d.m0_rdata", i), m0_rdata, tbl[i].erd);
            if (tbl[i].ev1) chk($sformatf("vec%0d.m1_rdata", i), m1_rdata, tbl[i].erd);
            model_step();
            @(posedge clk); #1;
        end

        // Random traffic: reads, byte writes, locks, withdrawals and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_lock  = ($urandom_range(0, 1) == 1);
            m1_lock  = ($urandom_range(0, 1) == 1);
            m0_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            m1_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            m0_addr  = {22'd0, 10'($urandom)};
            m1_addr  = {22'd0, 10'($urandom)};
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            @(negedge clk); model_step(); @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data-memory port between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug DMA).
- Sits between the requesters and the data memory. Address, write data and byte enables follow the same convention as the CPU data port: 32-bit address and data, 4-bit per-byte write enable, no read when all enables are 0.
- Arbitration is round-robin with optional lock for atomic sequences and a starvation limit.
- Memory has registered read: data for the address presented in cycle N is valid in cycle N+1.

Parameters:
- MAX_HOLD, 4: maximum consecutive grants to one port while the other port is requesting. Legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  port 0 request, held until granted.
- m0_lock  input  1  port 0 asks to keep ownership after this transfer.
- m0_addr  input  32  port 0 byte address.
- m0_wdata  input  32  port 0 write data, byte lanes pre-replicated by requester.
- m0_we  input  4  port 0 byte write enables; 4'b0000 means read.
- m0_gnt  output  1  port 0 transfer accepted this cycle.
- m0_rvalid  output  1  read data for port 0 valid this cycle.
- m0_rdata  output  32  read data to port 0.
- m1_req, m1_lock, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_we  output  4  memory byte enables.
- mem_en  output  1  memory access this cycle.
- mem_rdata  input  32  memory read data, one cycle after access.

Behaviour:
- Registered state:
  - owner FSM with states NONE, OWN0, OWN1 (last port granted).
  - lock_hold: 1 bit, last granted port requested lock.
  - hold_cnt: 4 bits, consecutive grants to the current owner while the other port requests.
  - rd_pend: 1 bit, plus rd_port: 1 bit.
- Reset: owner=NONE, lock_hold=0, hold_cnt=0, rd_pend=0. All outputs are 0 during the reset cycle, including gnt, rvalid, mem_en and mem_we. A read pending at reset never produces rvalid.
- Grant is combinational from req and registered state. At most one gnt is high per cycle. A transfer happens in any cycle where req&gnt.
- Priority when both ports request:
  - If lock_hold=1 and hold_cnt<MAX_HOLD, the owner wins.
  - Otherwise the non-owner wins.
  - From NONE, port 0 wins.
- Single requester: it is always granted, whatever lock or hold state.
- On a grant to port p:
  - owner<=OWNp.
  - lock_hold<=mp_lock.
  - hold_cnt<=hold_cnt+1 if p was already the owner and the other port is requesting this cycle; else hold_cnt<=1 if the other port is requesting; else 0. Saturates at MAX_HOLD.
- On a cycle with no grant: owner is unchanged, lock_hold<=0, hold_cnt<=0.
- Memory mux: mem_addr, mem_wdata and mem_we are taken from the granted port and mem_en=1. With no grant, mem_en=0, mem_we=0, and mem_addr and mem_wdata are 0.
- Read return: a granted transfer with we==0 sets rd_pend<=1 and rd_port<=p for the next cycle. In that cycle mp_rvalid=1, where p=rd_port.
- m0_rdata and m1_rdata both carry mem_rdata every cycle; rvalid qualifies it.
- Latency: read grant in cycle N gives rvalid in cycle N+1. Back-to-back reads return back-to-back rvalids.
- Writes produce no rvalid and complete in the grant cycle.
- A new grant may coincide with a rvalid from the previous cycle's read.
- The arbiter does not check address alignment. Byte enables pass through unchanged.
- Dropping req without gnt is permitted; the request is simply withdrawn.

Test Plan:
- Single read: after reset, m0 issues a read of 0x100 with we=0. Required: m0_gnt=1 and mem_en=1 in cycle N; m0_rvalid=1 in cycle N+1 with m0_rdata equal to mem_rdata (0xDEADBEEF from model); m1_rvalid stays 0.
- Contention: m0 and m1 both hold req for 4 cycles, no lock. Required grant sequence is m0, m1, m0, m1.
- Lock with starvation, MAX_HOLD=4: m1 alone is granted with lock=1, then m0 requests continuously while m1 keeps req and lock. Required: m1 granted 4 consecutive cycles from when m0 starts requesting, then m0 granted 1 cycle, then m1 again.
- Byte write: m1 writes with we=4'b0100, addr=0x202, wdata=0x55555555. Required: same cycle mem_we=4'b0100, mem_addr=0x202, mem_wdata=0x55555555; no rvalid follows.
- Reset mid-read: m0 read granted in cycle N and reset asserted in cycle N+1. Required: m0_rvalid=0 in N+1 and N+2, all gnt=0 during reset, and the first grant after reset follows NONE priority (port 0).
- Idle: no req for 3 cycles. Required: mem_en=0, mem_we=0, mem_addr=0; lock and hold state cleared; next contention grants the non-owner.
